cache_ref_ctrl: RTL and testbench

Upstream sequencer for the cache_set array. Accepts one memory reference at a time over a valid/ready handshake and decodes the address into tag, set index and offset. It then drives the set array through a search phase and an update phase, and returns hit/miss plus read data. It also keeps reference, hit and miss statistics for the simulator.

---
 rtl/cache_ref_ctrl.sv | 131 +++++++++++++
 tb/tb_cache_ref_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ref_ctrl.sv
// Reference sequencer for the cache_set array: accepts one reference, searches, samples,
// updates the selected set, then returns hit/miss and read data while keeping statistics.
module cache_ref_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TAG_W    = 27,
  parameter int unsigned INDEX_W  = 2,
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned OFFSET_W = 3,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_write,
  input  logic [DATA_W-1:0]          req_data,
  output logic [TAG_W-1:0]           set_tag,
  output logic                       set_state,
  output logic [NUM_SETS-1:0]        set_enable,
  output logic                       set_mem_write,
  output logic [DATA_W-1:0]          set_write_data,
  input  logic [NUM_SETS-1:0]        set_hit,
  input  logic [NUM_SETS*DATA_W-1:0] set_read_data,
  output logic                       resp_valid,
  output logic                       resp_hit,
  output logic [DATA_W-1:0]          resp_data,
  input  logic                       stat_clear,
  output logic [CNT_W-1:0]           ref_count,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count
);

  typedef enum logic [2:0] {StIdle, StSearch, StSample, StUpdate, StResp} state_e;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     tag_q;
  logic [INDEX_W-1:0]   index_q;
  logic                 write_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 hit_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [CNT_W-1:0]     ref_cnt_q, hit_cnt_q, miss_cnt_q;

  logic                 accept;
  logic                 sel_active;
  logic                 sel_hit;
  logic [DATA_W-1:0]    sel_rdata;
  logic [NUM_SETS-1:0]  index_onehot;

  // Offset bits only pick a byte within the line and play no part in set lookup.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign accept       = (state_q == StIdle) && req_valid;
  assign sel_active   = (state_q == StSearch) || (state_q == StSample) || (state_q == StUpdate);
  assign sel_hit      = set_hit[index_q];
  assign sel_rdata    = set_read_data[index_q*DATA_W +: DATA_W];
  assign index_onehot = NUM_SETS'(1) << index_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StSearch;
      StSearch: state_d = StSample;
      StSample: state_d = StUpdate;
      StUpdate: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == StIdle);
    set_tag        = sel_active ? tag_q : '0;
    set_enable     = sel_active ? index_onehot : '0;
    set_state      = (state_q == StUpdate);
    set_mem_write  = (state_q == StUpdate) && write_q;
    set_write_data = (state_q == StUpdate) ? wdata_q : '0;
    resp_valid     = (state_q == StResp);
    resp_hit       = (state_q == StResp) && hit_q;
    resp_data      = ((state_q == StResp) && hit_q) ? rdata_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tag_q   <= '0;
      index_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
        index_q <= req_addr[OFFSET_W +: INDEX_W];
        write_q <= req_write;
        wdata_q <= req_data;
      end
      if (state_q == StSample) begin
        hit_q   <= sel_hit;
        rdata_q <= sel_rdata;
      end
    end
  end

  // A clear landing on the response cycle discards that reference's count.
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      ref_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StResp) begin
      ref_cnt_q <= sat_inc(ref_cnt_q);
      if (hit_q) hit_cnt_q  <= sat_inc(hit_cnt_q);
      else       miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign ref_count  = ref_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ref_ctrl.sv
// Bench for cache_ref_ctrl: directed scenarios with literal expectations plus random traffic
// compared every cycle against a transaction-level model of the reference timeline.
module tb_cache_ref_ctrl;
  localparam int unsigned ADDR_W = 32, TAG_W = 27, INDEX_W = 2, NUM_SETS = 4;
  localparam int unsigned OFFSET_W = 3, DATA_W = 64, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data, set_write_data, resp_data;
  logic [TAG_W-1:0] set_tag;
  logic set_state, set_mem_write, resp_valid, resp_hit, stat_clear;
  logic [NUM_SETS-1:0] set_enable, set_hit;
  logic [NUM_SETS*DATA_W-1:0] set_read_data;
  logic [CNT_W-1:0] ref_count, hit_count, miss_count;

  cache_ref_ctrl #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .NUM_SETS(NUM_SETS),
    .OFFSET_W(OFFSET_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_data(req_data),
    .set_tag(set_tag), .set_state(set_state), .set_enable(set_enable),
    .set_mem_write(set_mem_write), .set_write_data(set_write_data),
    .set_hit(set_hit), .set_read_data(set_read_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .stat_clear(stat_clear), .ref_count(ref_count), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: an outstanding reference is described by its accept cycle; every output follows
  // from how many cycles have elapsed since then.
  logic m_busy = 1'b0;
  int m_acc = 0, m_age = 0;
  logic [TAG_W-1:0] m_tag = '0;
  int m_idx = 0;
  logic m_wr = 1'b0, m_hit = 1'b0;
  logic [DATA_W-1:0] m_wd = '0, m_rd = '0;
  int m_ref = 0, m_hits = 0, m_miss = 0;

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  initial begin
    logic sel, upd, rsp;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        m_age = m_busy ? cyc - m_acc : 0;
        sel = m_busy && m_age >= 1 && m_age <= 3;
        upd = m_busy && m_age == 3;
        rsp = m_busy && m_age == 4;
        chk("req_ready", req_ready, !m_busy);
        chk("set_enable", set_enable, sel ? 64'(1 << m_idx) : 64'd0);
        chk("set_tag", set_tag, sel ? 64'(m_tag) : 64'd0);
        chk("set_state", set_state, upd);
        chk("set_mem_write", set_mem_write, upd && m_wr);
        chk("set_write_data", set_write_data, upd ? m_wd : 64'd0);
        chk("resp_valid", resp_valid, rsp);
        chk("resp_hit", resp_hit, rsp && m_hit);
        chk("resp_data", resp_data, (rsp && m_hit) ? m_rd : 64'd0);
        chk("ref_count", ref_count, 64'(m_ref));
        chk("hit_count", hit_count, 64'(m_hits));
        chk("miss_count", miss_count, 64'(m_miss));
        if (m_busy && m_age == 2) begin
          m_hit = set_hit[m_idx];
          m_rd  = set_read_data[m_idx*DATA_W +: DATA_W];
        end
        if (rst) begin
          m_busy = 1'b0; m_ref = 0; m_hits = 0; m_miss = 0;
        end else begin
          if (stat_clear) begin
            m_ref = 0; m_hits = 0; m_miss = 0;
          end else if (rsp) begin
            m_ref = sat(m_ref);
            if (m_hit) m_hits = sat(m_hits);
            else m_miss = sat(m_miss);
          end
          if (rsp) m_busy = 1'b0;
          else if (!m_busy && req_valid) begin
            m_busy = 1'b1; m_acc = cyc;
            m_tag = req_addr[ADDR_W-1 -: TAG_W];
            m_idx = int'(req_addr[OFFSET_W +: INDEX_W]);
            m_wr = req_write; m_wd = req_data;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [31:0] a, input logic w, input logic [63:0] d,
                        output int acc);
    acc = -1;
    req_addr = a; req_write = w; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) acc = cyc;
      step();
      if (acc >= 0) break;
    end
    // Scramble the request bus so only the latched copy can be used.
    req_valid = 1'b0; req_addr = $urandom; req_data = {$urandom, $urandom}; req_write = ~w;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_resp(input int acc, output int lat, output logic [3:0] en,
                           output logic [TAG_W-1:0] tg, output logic h, output logic [63:0] rd);
    lat = -1; en = '0; tg = '0; h = 1'b0; rd = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin en = set_enable; tg = set_tag; end
      if (lat < 0 && resp_valid) begin lat = cyc - acc; h = resp_hit; rd = resp_data; end
      step();
      if (lat >= 0) break;
    end
    if (lat < 0) chk("resp_timeout", 0, 1);
  endtask

  int acc, lat;
  int acc_list[3];
  int n_acc;
  logic [3:0] en;
  logic [TAG_W-1:0] tg;
  logic h;
  logic [63:0] rd;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    set_hit = '0; set_read_data = '0; stat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", req_ready, 1);
      chk("idle_enable", set_enable, 0);
    end
    chk("idle_ref_count", ref_count, 0);
    step();

    // Miss decode
    set_hit = 4'b0000;
    set_read_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    accept(32'h0000_0008, 1'b0, 64'h1111, acc);
    wait_resp(acc, lat, en, tg, h, rd);
    chk("miss_latency", lat, 4);
    chk("miss_enable", en, 4'b0010);
    chk("miss_tag", tg, 0);
    chk("miss_hit", h, 0);
    chk("miss_data", rd, 0);
    @(negedge clk); #1;
    chk("miss_count_lit", miss_count, 1);
    chk("miss_ref_lit", ref_count, 1);
    chk("model_miss_pin", m_miss, 1);
    step();

    // Hit data path
    set_hit = 4'b1000;
    set_read_data = {64'hDEAD_BEEF_0123_4567, 64'hAAAA_5555_AAAA_5555, {$urandom, $urandom},
                     {$urandom, $urandom}};
    accept(32'hFFFF_FFF8, 1'b1, 64'h0BAD_F00D_CAFE_0001, acc);
    wait_resp(acc, lat, en, tg, h, rd);
    chk("hit_enable", en, 4'b1000);
    chk("hit_tag", tg, 27'h7FF_FFFF);
    chk("hit_flag", h, 1);
    chk("hit_data", rd, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk); #1;
    chk("hit_count_lit", hit_count, 1);
    chk("model_hits_pin", m_hits, 1);
    step();

    // Wrong-set hit ignored
    set_hit = 4'b0100;
    accept(32'h0000_0100, 1'b0, 64'h0, acc);
    wait_resp(acc, lat, en, tg, h, rd);
    chk("wrongset_enable", en, 4'b0001);
    chk("wrongset_tag", tg, 27'h8);
    chk("wrongset_hit", h, 0);
    chk("wrongset_data", rd, 0);
    @(negedge clk);
    chk("wrongset_miss_lit", miss_count, 2);
    step();

    // Back-pressure: req_valid held for three references
    stat_clear = 1'b1; step(); stat_clear = 1'b0;
    set_hit = 4'b1111;
    n_acc = 0; req_valid = 1'b1; req_addr = 32'h0000_0010;
    for (int i = 0; i < 40 && n_acc < 3; i++) begin
      @(negedge clk);
      if (req_ready) begin acc_list[n_acc] = cyc; n_acc++; end
      step();
      if (n_acc == 3) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("bp_accepts", n_acc, 3);
    chk("bp_gap1", acc_list[1] - acc_list[0], 5);
    chk("bp_gap2", acc_list[2] - acc_list[1], 5);
    repeat (6) step();
    @(negedge clk);
    chk("bp_ref_lit", ref_count, 3);
    chk("bp_hit_lit", hit_count, 3);
    step();

    // Reset during UPDATE aborts the reference
    accept(32'h0000_0018, 1'b1, 64'h5, acc);
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_update", set_state, 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    chk("abort_ref", ref_count, 0);
    chk("abort_hits", hit_count, 0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_resp", resp_valid, 0);
      step(); @(negedge clk);
    end
    step();

    // stat_clear colliding with the response cycle
    set_hit = 4'b0000;
    accept(32'h0000_0000, 1'b0, 64'h0, acc);
    wait_resp(acc, lat, en, tg, h, rd);
    accept(32'h0000_0008, 1'b0, 64'h0, acc);
    repeat (3) step();
    stat_clear = 1'b1;
    @(negedge clk);
    chk("clr_in_resp", resp_valid, 1);
    step();
    stat_clear = 1'b0;
    @(negedge clk);
    chk("clr_ref", ref_count, 0);
    chk("clr_miss", miss_count, 0);
    step();

    // Saturation: 17 misses into a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      accept($urandom, 1'b0, 64'h0, acc);
      wait_resp(acc, lat, en, tg, h, rd);
    end
    @(negedge clk);
    chk("sat_miss_lit", miss_count, 15);
    chk("sat_ref_lit", ref_count, 15);
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid  = ($urandom_range(0, 1) == 1);
      req_addr   = $urandom;
      req_write  = $urandom_range(0, 1) == 1;
      req_data   = {$urandom, $urandom};
      set_hit    = 4'($urandom);
      set_read_data = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
      stat_clear = ($urandom_range(0, 63) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; req_valid = 1'b0; stat_clear = 1'b0;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
